// File: rtl/bmem_arbiter.sv
// N-port burst-memory arbiter: round-robin request grant, whole-burst writes, in-order read-response routing.
// Latency: 1 cycle from request to downstream assertion (IDLE -> GRANT); responses routed combinationally.
// Backpressure: bmem_ready stalls the granted port; a full owner FIFO holds read grants; responses are never stalled.
// Optional build macro BMEM_ARB_FIXED_PRIO_EN: lowest-index requester always wins, rr_ptr stays 0.
module bmem_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 64,
  parameter int BURST_LEN       = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic [ADDR_W-1:0]           resp_raddr,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic [NUM_PORTS-1:0]        resp_rvalid,
  output logic [ADDR_W-1:0]           bmem_addr,
  output logic                        bmem_read,
  output logic                        bmem_write,
  output logic [DATA_W-1:0]           bmem_wdata,
  input  logic                        bmem_ready,
  input  logic [ADDR_W-1:0]           bmem_raddr,
  input  logic [DATA_W-1:0]           bmem_rdata,
  input  logic                        bmem_rvalid,
  output logic                        protocol_err
);

  localparam int ID_W  = $clog2(NUM_PORTS);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OCC_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_PORTS - 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [OCC_W-1:0] FULL_OCC  = OCC_W'(MAX_OUTSTANDING);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t r_state, w_state_nxt;

  logic [ID_W-1:0]  r_grant_id;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [CNT_W-1:0] r_wbeat;
  logic [CNT_W-1:0] r_rbeat;
  logic             r_protocol_err;

  // Owner FIFO: one entry per accepted read burst, holding the requesting port id.
  logic [ID_W-1:0]  r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;

  logic [NUM_PORTS-1:0] w_req;
  logic                 w_found;
  logic [ID_W-1:0]      w_pick;
  logic                 w_g_read;
  logic                 w_g_write;
  logic [ADDR_W-1:0]    w_g_addr;
  logic [DATA_W-1:0]    w_g_wdata;
  logic [NUM_PORTS-1:0] w_gnt_onehot;
  logic                 w_rdy_g;
  logic                 w_push;
  logic                 w_wbeat_acc;
  logic                 w_rr_upd;
  logic                 w_collide;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic                 w_beat_acc;
  logic                 w_pop;

  assign w_req        = req_read | req_write;
  assign w_gnt_onehot = NUM_PORTS'(1) << r_grant_id;
  assign req_ready    = w_gnt_onehot & {NUM_PORTS{w_rdy_g}};

  // Pick the first requester at or after rr_ptr: scan the upper segment, then wrap to the bottom.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!w_found && w_req[j] && (ID_W'(j) >= r_rr_ptr)) begin
        w_found = 1'b1;
        w_pick  = ID_W'(j);
      end
    end
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!w_found && w_req[j]) begin
        w_found = 1'b1;
        w_pick  = ID_W'(j);
      end
    end
  end

  // Select the granted port's request fields.
  always_comb begin
    w_g_read  = 1'b0;
    w_g_write = 1'b0;
    w_g_addr  = '0;
    w_g_wdata = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (r_grant_id == ID_W'(j)) begin
        w_g_read  = req_read[j];
        w_g_write = req_write[j];
        w_g_addr  = req_addr[j*ADDR_W +: ADDR_W];
        w_g_wdata = req_wdata[j*DATA_W +: DATA_W];
      end
    end
  end

  // FSM next state and downstream drive; write wins when the owner asserts both.
  always_comb begin
    w_state_nxt = r_state;
    bmem_addr   = '0;
    bmem_read   = 1'b0;
    bmem_write  = 1'b0;
    bmem_wdata  = '0;
    w_rdy_g     = 1'b0;
    w_push      = 1'b0;
    w_wbeat_acc = 1'b0;
    w_rr_upd    = 1'b0;
    w_collide   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_state_nxt = S_GRANT;
      end
      S_GRANT: begin
        bmem_addr  = w_g_addr;
        bmem_wdata = w_g_wdata;
        if (w_g_write) begin
          bmem_write = 1'b1;
          w_rdy_g    = bmem_ready;
          w_collide  = w_g_read;
          if (bmem_ready) begin
            w_wbeat_acc = 1'b1;
            if (r_wbeat == LAST_BEAT) begin
              w_rr_upd    = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
        end else if (w_g_read && (r_wbeat == '0)) begin
          // Full is the registered occupancy, so a same-cycle pop cannot open a slot.
          if (!w_fifo_full) begin
            bmem_read = 1'b1;
            w_rdy_g   = bmem_ready;
            if (bmem_ready) begin
              w_push      = 1'b1;
              w_rr_upd    = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
        end else if (r_wbeat == '0) begin
          // Owner withdrew before any beat was accepted; fairness pointer untouched.
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, grant id, fairness pointer and write-beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_wbeat    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && w_found) r_grant_id <= w_pick;
`ifdef BMEM_ARB_FIXED_PRIO_EN
      r_rr_ptr <= '0;
`else
      if (w_rr_upd) r_rr_ptr <= (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
`endif
      if (w_wbeat_acc) r_wbeat <= (r_wbeat == LAST_BEAT) ? '0 : r_wbeat + 1'b1;
    end
  end

  assign w_fifo_empty = (r_occ == '0);
  assign w_fifo_full  = (r_occ == FULL_OCC);
  assign w_beat_acc   = bmem_rvalid & ~w_fifo_empty;
  assign w_pop        = w_beat_acc & (r_rbeat == LAST_BEAT);

  assign resp_raddr  = bmem_raddr;
  assign resp_rdata  = bmem_rdata;
  assign resp_rvalid = (NUM_PORTS'(1) << r_fifo[r_rd_ptr]) & {NUM_PORTS{w_beat_acc}};

  // Owner FIFO push on read acceptance, pop on the last response beat of a burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_fifo[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= r_grant_id;
        r_wr_ptr         <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      if (w_push && !w_pop) r_occ <= r_occ + 1'b1;
      else if (!w_push && w_pop) r_occ <= r_occ - 1'b1;
    end
  end

  // Response beat counter within the current burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rbeat <= '0;
    end else if (w_beat_acc) begin
      r_rbeat <= w_pop ? '0 : r_rbeat + 1'b1;
    end
  end

  // Sticky error: read/write collision or a response beat with nothing outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_protocol_err <= 1'b0;
    end else if (w_collide || (bmem_rvalid && w_fifo_empty)) begin
      r_protocol_err <= 1'b1;
    end
  end

  assign protocol_err = r_protocol_err;

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed bench for bmem_arbiter (2 ports, 32b addr, 64b data, 4-beat bursts, 4 outstanding reads).
module tb_bmem_arbiter;
  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BL = 4;
  localparam int MO = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NP*AW-1:0] req_addr;
  logic [NP-1:0]   req_read;
  logic [NP-1:0]   req_write;
  logic [NP*DW-1:0] req_wdata;
  logic [NP-1:0]   req_ready;
  logic [AW-1:0]   resp_raddr;
  logic [DW-1:0]   resp_rdata;
  logic [NP-1:0]   resp_rvalid;
  logic [AW-1:0]   bmem_addr;
  logic            bmem_read;
  logic            bmem_write;
  logic [DW-1:0]   bmem_wdata;
  logic            bmem_ready;
  logic [AW-1:0]   bmem_raddr;
  logic [DW-1:0]   bmem_rdata;
  logic            bmem_rvalid;
  logic            protocol_err;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] wbeats [BL];

  bmem_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_addr(req_addr), .req_read(req_read), .req_write(req_write), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .resp_raddr(resp_raddr), .resp_rdata(resp_rdata), .resp_rvalid(resp_rvalid),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
    .bmem_ready(bmem_ready),
    .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  // Request a read on port p and hold it until accepted (bounded).
  task automatic issue_read(input int p, input logic [AW-1:0] addr);
    bit got;
    got = 1'b0;
    req_read[p] = 1'b1;
    req_addr[p*AW +: AW] = addr;
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if (req_ready[p]) begin
        got = 1'b1;
        total++;
        if (bmem_addr !== addr) begin
          bad++;
          $display("FAIL rd_addr port%0d: got %h want %h", p, bmem_addr, addr);
        end
      end
      tick;
    end
    req_read[p] = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL rd_accept port%0d: no req_ready within 20 cycles", p);
    end
  endtask

  // Return one response burst and check routing to the expected owner.
  task automatic drain_burst(input int owner, input logic [AW-1:0] base);
    logic [NP-1:0] exp;
    logic [AW-1:0] ea;
    exp = '0;
    exp[owner] = 1'b1;
    for (int b = 0; b < BL; b++) begin
      ea = base + AW'(8 * b);
      bmem_rvalid = 1'b1;
      bmem_raddr  = ea;
      bmem_rdata  = {32'hDA7A0000, ea};
      #1;
      total++;
      if (resp_rvalid !== exp) begin
        bad++;
        $display("FAIL resp_rvalid beat%0d: got %b want %b", b, resp_rvalid, exp);
      end
      total++;
      if (resp_raddr !== ea) begin
        bad++;
        $display("FAIL resp_raddr beat%0d: got %h want %h", b, resp_raddr, ea);
      end
      total++;
      if (resp_rdata !== {32'hDA7A0000, ea}) begin
        bad++;
        $display("FAIL resp_rdata beat%0d: got %h want %h", b, resp_rdata, {32'hDA7A0000, ea});
      end
      tick;
    end
    bmem_rvalid = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bmem_read, bmem_write, req_ready, resp_rvalid, protocol_err} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got rd=%b wr=%b rdy=%b rv=%b err=%b want all 0",
               bmem_read, bmem_write, req_ready, resp_rvalid, protocol_err);
    end
    total++;
    if (bmem_addr !== '0 || bmem_wdata !== '0) begin
      bad++;
      $display("FAIL reset_data: got addr=%h wdata=%h want 0", bmem_addr, bmem_wdata);
    end
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    // Move rr_ptr off 0, then start a port-1 write burst and reset during beat 2.
    issue_read(0, 32'h10);
    req_write[1] = 1'b1;
    req_addr[AW +: AW] = 32'h3000;
    req_wdata[DW +: DW] = wbeats[0];
    tick;
    for (int b = 0; b < 2; b++) begin
      req_wdata[DW +: DW] = wbeats[b];
      #1;
      tick;
    end
    req_wdata[DW +: DW] = wbeats[2];
    #1;
    total++;
    if (bmem_write !== 1'b1) begin
      bad++;
      $display("FAIL midburst_write: got %b want 1", bmem_write);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bmem_read, bmem_write, req_ready, resp_rvalid, protocol_err} !== 7'b0 ||
        bmem_addr !== '0 || bmem_wdata !== '0) begin
      bad++;
      $display("FAIL async_reset: got rd=%b wr=%b rdy=%b addr=%h wdata=%h want all 0",
               bmem_read, bmem_write, req_ready, bmem_addr, bmem_wdata);
    end
    @(posedge clk);
    #1;
    req_write = '0;
    rst_n = 1'b1;
    req_read = 2'b11;
    req_addr[0 +: AW]  = 32'h20;
    req_addr[AW +: AW] = 32'h30;
    #1;
    total++;
    if (bmem_read !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: got bmem_read=%b want 0", bmem_read);
    end
    tick;
    #1;
    total++;
    if (req_ready !== 2'b01 || bmem_addr !== 32'h20) begin
      bad++;
      $display("FAIL post_reset_grant: got rdy=%b addr=%h want rdy=01 addr=00000020", req_ready, bmem_addr);
    end
    tick;
    req_read = '0;
    drain_burst(0, 32'h20);
  endtask

  task automatic test_fairness;
    int port;
    logic [NP-1:0] erdy;
    do_reset;
    req_read = 2'b11;
    req_addr[0 +: AW]  = 32'hA00;
    req_addr[AW +: AW] = 32'hB00;
    for (int k = 0; k < 8; k++) begin
      erdy = '0;
      if (k % 2 == 1) begin
`ifdef BMEM_ARB_FIXED_PRIO_EN
        port = 0;
`else
        port = ((k - 1) / 2) % 2;
`endif
        erdy[port] = 1'b1;
      end
      #1;
      total++;
      if (req_ready !== erdy || bmem_read !== (k % 2 == 1)) begin
        bad++;
        $display("FAIL rr_cycle%0d: got rdy=%b rd=%b want rdy=%b rd=%0d", k, req_ready, bmem_read, erdy, k % 2);
      end
      tick;
    end
    req_read = '0;
    for (int k = 0; k < 4; k++) begin
`ifdef BMEM_ARB_FIXED_PRIO_EN
      drain_burst(0, 32'hA00);
`else
      drain_burst(k % 2, (k % 2 == 0) ? 32'hA00 : 32'hB00);
`endif
    end
  endtask

  task automatic test_write_burst;
    int wb;
    wb = 0;
    req_write[1] = 1'b1;
    req_addr[AW +: AW] = 32'h1000;
    req_wdata[DW +: DW] = wbeats[0];
    tick;
    req_read[0] = 1'b1;
    req_addr[0 +: AW] = 32'h2000;
    for (int c = 1; c <= 6; c++) begin
      bmem_ready = (c != 2);
      if (wb < BL) req_wdata[DW +: DW] = wbeats[wb];
      else req_write[1] = 1'b0;
      #1;
      total++;
      if (bmem_read !== 1'b0) begin
        bad++;
        $display("FAIL wr_read_early cyc%0d: got bmem_read=%b want 0", c, bmem_read);
      end
      if (c == 2) begin
        total++;
        if (req_ready !== 2'b00 || bmem_write !== 1'b1) begin
          bad++;
          $display("FAIL wr_stall: got rdy=%b wr=%b want rdy=00 wr=1", req_ready, bmem_write);
        end
      end
      if (bmem_write && bmem_ready) begin
        total++;
        if (wb >= BL || bmem_wdata !== wbeats[wb] || bmem_addr !== 32'h1000) begin
          bad++;
          $display("FAIL wr_beat%0d: got wdata=%h addr=%h", wb, bmem_wdata, bmem_addr);
        end
        wb++;
      end
      tick;
    end
    bmem_ready = 1'b1;
    total++;
    if (wb !== BL) begin
      bad++;
      $display("FAIL wr_beat_count: got %0d want %0d", wb, BL);
    end
    #1;
    total++;
    if (bmem_read !== 1'b1 || req_ready !== 2'b01 || bmem_addr !== 32'h2000) begin
      bad++;
      $display("FAIL rd_after_write: got rd=%b rdy=%b addr=%h want rd=1 rdy=01 addr=00002000",
               bmem_read, req_ready, bmem_addr);
    end
    tick;
    req_read = '0;
    drain_burst(0, 32'h2000);
  endtask

  task automatic test_responses;
    issue_read(0, 32'h40);
    issue_read(1, 32'h80);
    drain_burst(0, 32'h40);
    drain_burst(1, 32'h80);
  endtask

  task automatic test_fifo_full;
    issue_read(0, 32'h100);
    issue_read(0, 32'h200);
    issue_read(0, 32'h300);
    issue_read(0, 32'h400);
    req_read[1] = 1'b1;
    req_addr[AW +: AW] = 32'h500;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (bmem_read !== 1'b0 || req_ready !== 2'b00) begin
        bad++;
        $display("FAIL full_hold cyc%0d: got rd=%b rdy=%b want 0/00", k, bmem_read, req_ready);
      end
      tick;
    end
    for (int b = 0; b < BL; b++) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = 32'h100 + AW'(8 * b);
      #1;
      total++;
      if (resp_rvalid !== 2'b01 || bmem_read !== 1'b0) begin
        bad++;
        $display("FAIL full_pop beat%0d: got rv=%b rd=%b want rv=01 rd=0", b, resp_rvalid, bmem_read);
      end
      tick;
    end
    bmem_rvalid = 1'b0;
    bmem_raddr  = '0;
    #1;
    total++;
    if (bmem_read !== 1'b1 || req_ready !== 2'b10 || bmem_addr !== 32'h500) begin
      bad++;
      $display("FAIL full_release: got rd=%b rdy=%b addr=%h want rd=1 rdy=10 addr=00000500",
               bmem_read, req_ready, bmem_addr);
    end
    tick;
    req_read = '0;
    drain_burst(0, 32'h200);
    drain_burst(0, 32'h300);
    drain_burst(0, 32'h400);
    drain_burst(1, 32'h500);
  endtask

  task automatic test_error;
    #1;
    total++;
    if (protocol_err !== 1'b0) begin
      bad++;
      $display("FAIL err_clean: got %b want 0", protocol_err);
    end
    bmem_rvalid = 1'b1;
    bmem_raddr  = 32'h77;
    #1;
    total++;
    if (resp_rvalid !== 2'b00) begin
      bad++;
      $display("FAIL err_drop: got rv=%b want 00", resp_rvalid);
    end
    tick;
    bmem_rvalid = 1'b0;
    bmem_raddr  = '0;
    #1;
    total++;
    if (protocol_err !== 1'b1) begin
      bad++;
      $display("FAIL err_set: got %b want 1", protocol_err);
    end
    for (int k = 0; k < 5; k++) tick;
    total++;
    if (protocol_err !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: got %b want 1", protocol_err);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (protocol_err !== 1'b0) begin
      bad++;
      $display("FAIL err_reset: got %b want 0", protocol_err);
    end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_collision;
    req_read[0]  = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0 +: AW] = 32'h900;
    req_wdata[0 +: DW] = wbeats[0];
    tick;
    for (int b = 0; b < BL; b++) begin
      req_wdata[0 +: DW] = wbeats[b];
      #1;
      total++;
      if (bmem_write !== 1'b1 || bmem_read !== 1'b0 || bmem_wdata !== wbeats[b]) begin
        bad++;
        $display("FAIL collide_beat%0d: got wr=%b rd=%b wdata=%h want wr=1 rd=0 wdata=%h",
                 b, bmem_write, bmem_read, bmem_wdata, wbeats[b]);
      end
      tick;
    end
    req_read  = '0;
    req_write = '0;
    bmem_rvalid = 1'b1;
    #1;
    total++;
    if (protocol_err !== 1'b1 || resp_rvalid !== 2'b00) begin
      bad++;
      $display("FAIL collide_err: got err=%b rv=%b want err=1 rv=00", protocol_err, resp_rvalid);
    end
    tick;
    bmem_rvalid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < BL; i++) wbeats[i] = 64'hAAAA_0000_0000_00A0 + DW'(i);
    rst_n       = 1'b0;
    req_addr    = '0;
    req_read    = '0;
    req_write   = '0;
    req_wdata   = '0;
    bmem_ready  = 1'b1;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
    bmem_rvalid = 1'b0;
    test_reset;
    test_fairness;
    test_write_burst;
    test_responses;
    test_fifo_full;
    test_error;
    test_collision;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
